// File: rtl/fft_frame_ctrl.sv
// Ping-pong sample buffer and start/done sequencer for a streaming FFT core.
// Optional drop counter output enabled by FFT_FRAME_DROP_COUNT_EN.
module fft_frame_ctrl #(
    parameter int WIDTH = 12,
    parameter int N     = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic signed [WIDTH-1:0] fft_samples [0:N-1],
    output logic                    frame_done,
    output logic                    overflow,
`ifdef FFT_FRAME_DROP_COUNT_EN
    output logic [7:0]              drop_count,
`endif
    output logic                    busy
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic              fill_sel_q, fill_sel_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              comp_sel;

    logic signed [WIDTH-1:0] bank_q [0:1][0:N-1];

    assign full     = sample_valid && (wptr_q == LAST);
    assign comp_sel = ~fill_sel_q;

    always_comb begin
        wptr_d = wptr_q;
        if (sample_valid) begin
            wptr_d = wptr_q + AW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_sel_d   = fill_sel_q;
        frame_done_d = 1'b0;
        overflow_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full) begin
                    fill_sel_d = ~fill_sel_q;
                    state_d    = START;
                end
            end
            START: begin
                state_d = BUSY;
                if (full) begin
                    overflow_d = 1'b1;
                end
            end
            BUSY: begin
                if (fft_done) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                    // A frame completing on the done cycle reuses the freed bank
                    if (full) begin
                        fill_sel_d = ~fill_sel_q;
                        state_d    = START;
                    end
                end else if (full) begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            fill_sel_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            fill_sel_q   <= fill_sel_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Sample storage carries no reset
    always_ff @(posedge clk) begin
        if (!rst && sample_valid) begin
            bank_q[fill_sel_q][wptr_q] <= sample_in;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            fft_samples[k] = bank_q[comp_sel][k];
        end
    end

    assign fft_start  = (state_q == START);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

`ifdef FFT_FRAME_DROP_COUNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (overflow_d && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomised bench for fft_frame_ctrl against a frame-level reference model.
// Define FFT_FRAME_DROP_COUNT_EN to also exercise the drop counter.
module tb_fft_frame_ctrl;

    localparam int WIDTH = 12;
    localparam int N     = 256;

    logic                    clk;
    logic                    rst;
    logic                    sample_valid;
    logic signed [WIDTH-1:0] sample_in;
    logic                    fft_start;
    logic                    fft_done;
    logic signed [WIDTH-1:0] fft_samples [0:N-1];
    logic                    frame_done;
    logic                    overflow;
    logic                    busy;
`ifdef FFT_FRAME_DROP_COUNT_EN
    logic [7:0]              drop_count;
`endif

    fft_frame_ctrl #(.WIDTH(WIDTH), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .fft_samples  (fft_samples),
        .frame_done   (frame_done),
        .overflow     (overflow),
`ifdef FFT_FRAME_DROP_COUNT_EN
        .drop_count   (drop_count),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Model: frame being collected, frame owned by the FFT, ownership phase
    // (0 = free, 1 = start cycle, 2 = FFT computing), saturating drop tally.
    int                m_cnt;
    int                m_phase;
    int                m_drop;
    logic [WIDTH-1:0]  m_frame [N];
    logic [WIDTH-1:0]  m_comp  [N];
    int                ov_seen;
    int                both_seen;

    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic dn);
        logic full, free, e_st, e_fd, e_ov, bad;
        int   nph;
        rst          = 1'b0;
        sample_valid = v;
        sample_in    = d;
        fft_done     = dn;
        full = v && (m_cnt == N - 1);
        if (v) m_frame[m_cnt] = d;
        e_fd = (m_phase == 2) && dn;
        free = (m_phase == 0) || e_fd;
        e_st = 1'b0;
        e_ov = 1'b0;
        if (m_phase == 1) nph = 2;
        else if (e_fd) nph = 0;
        else nph = m_phase;
        if (full && free) begin
            e_st = 1'b1;
            nph  = 1;
            m_comp = m_frame;
        end else if (full) begin
            e_ov = 1'b1;
        end
        m_phase = nph;
        if (v) m_cnt = (m_cnt + 1) % N;
        if (e_ov && m_drop < 255) m_drop++;
        @(posedge clk);
        #1;
        if (overflow) ov_seen++;
        if (frame_done && fft_start) both_seen++;
        checks += 4;
        if (fft_start !== e_st) begin
            failures++;
            $display("FAIL step_start t=%0t got=%b exp=%b", $time, fft_start, e_st);
        end
        if (frame_done !== e_fd) begin
            failures++;
            $display("FAIL step_frame_done t=%0t got=%b exp=%b", $time, frame_done, e_fd);
        end
        if (overflow !== e_ov) begin
            failures++;
            $display("FAIL step_overflow t=%0t got=%b exp=%b", $time, overflow, e_ov);
        end
        if (busy !== (m_phase != 0)) begin
            failures++;
            $display("FAIL step_busy t=%0t got=%b exp=%b", $time, busy, m_phase != 0);
        end
        if (m_phase != 0) begin
            bad = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (fft_samples[k] !== m_comp[k]) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL step_samples t=%0t got[0]=%0h exp[0]=%0h", $time, fft_samples[0], m_comp[0]);
            end
        end
`ifdef FFT_FRAME_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'(m_drop)) begin
            failures++;
            $display("FAIL step_drop t=%0t got=%0d exp=%0d", $time, drop_count, m_drop);
        end
`endif
    endtask

    task automatic do_reset(input logic v, input logic dn);
        rst          = 1'b1;
        sample_valid = v;
        sample_in    = WIDTH'($urandom);
        fft_done     = dn;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        m_cnt   = 0;
        m_phase = 0;
        m_drop  = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        checks += 4;
        if (fft_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_start got=%b exp=0", fft_start);
        end
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%b exp=0", overflow);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
`ifdef FFT_FRAME_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_drop got=%0d exp=0", drop_count);
        end
`endif
    endtask

    task automatic test_first_frame();
        logic bad;
        for (int i = 0; i < N; i++) step(1'b1, WIDTH'(i), 1'b0);
        bad = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (fft_samples[k] !== WIDTH'(k)) bad = 1'b1;
        end
        checks += 3;
        if (fft_start !== 1'b1) begin
            failures++;
            $display("FAIL first_start got=%b exp=1", fft_start);
        end
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL first_busy got=%b exp=1", busy);
        end
        if (bad) begin
            failures++;
            $display("FAIL first_samples got[7]=%0d exp[7]=7", fft_samples[7]);
        end
    endtask

    task automatic test_overflow();
        int   ov0;
        logic bad;
        ov0 = ov_seen;
        for (int i = 0; i < 2 * N; i++) step(1'b1, WIDTH'($urandom), 1'b0);
        bad = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (fft_samples[k] !== WIDTH'(k)) bad = 1'b1;
        end
        checks += 3;
        if (ov_seen - ov0 != 2) begin
            failures++;
            $display("FAIL ovf_count got=%0d exp=2", ov_seen - ov0);
        end
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ovf_busy got=%b exp=1", busy);
        end
        if (bad) begin
            failures++;
            $display("FAIL ovf_samples got[9]=%0d exp[9]=9", fft_samples[9]);
        end
`ifdef FFT_FRAME_DROP_COUNT_EN
        checks++;
        if (drop_count !== 8'd2) begin
            failures++;
            $display("FAIL ovf_drop got=%0d exp=2", drop_count);
        end
`endif
    endtask

    task automatic test_done();
        step(1'b0, '0, 1'b1);
        checks += 3;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse got=%b exp=1", frame_done);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL done_busy got=%b exp=0", busy);
        end
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL done_overflow got=%b exp=0", overflow);
        end
        step(1'b0, '0, 1'b0);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL done_width got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_coincident();
        logic [WIDTH-1:0] fb [N];
        int   ov0;
        logic bad;
        for (int i = 0; i < N; i++) step(1'b1, WIDTH'($urandom), 1'b0);
        ov0 = ov_seen;
        for (int i = 0; i < N; i++) begin
            fb[i] = WIDTH'($urandom);
            step(1'b1, fb[i], (i == N - 1));
        end
        bad = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (fft_samples[k] !== fb[k]) bad = 1'b1;
        end
        checks += 3;
        if (!(frame_done === 1'b1 && fft_start === 1'b1)) begin
            failures++;
            $display("FAIL coinc_pulses got=%b%b exp=11", frame_done, fft_start);
        end
        if (ov_seen != ov0) begin
            failures++;
            $display("FAIL coinc_overflow got=%0d exp=0", ov_seen - ov0);
        end
        if (bad) begin
            failures++;
            $display("FAIL coinc_samples got[0]=%0h exp[0]=%0h", fft_samples[0], fb[0]);
        end
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_busy();
        do_reset(1'b0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        checks++;
        if ({fft_start, frame_done, overflow, busy} !== 4'b0) begin
            failures++;
            $display("FAIL rbusy_outputs got=%b exp=0000", {fft_start, frame_done, overflow, busy});
        end
        for (int i = 0; i < N; i++) step(1'b1, WIDTH'($urandom), 1'b0);
        checks++;
        if (fft_start !== 1'b1) begin
            failures++;
            $display("FAIL rbusy_wptr got=%b exp=1", fft_start);
        end
    endtask

    task automatic test_random();
        do_reset(1'($urandom), 1'($urandom));
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0, WIDTH'($urandom),
                 $urandom_range(0, 19) == 0);
        end
    endtask

`ifdef FFT_FRAME_DROP_COUNT_EN
    task automatic test_drop_sat();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 301 * N; i++) step(1'b1, WIDTH'($urandom), 1'b0);
        checks++;
        if (drop_count !== 8'd255) begin
            failures++;
            $display("FAIL drop_sat got=%0d exp=255", drop_count);
        end
    endtask
`endif

    initial begin
        checks       = 0;
        failures     = 0;
        ov_seen      = 0;
        both_seen    = 0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        fft_done     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_first_frame();
        test_overflow();
        test_done();
        test_coincident();
        test_reset_busy();
        test_random();
`ifdef FFT_FRAME_DROP_COUNT_EN
        test_drop_sat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 12: signed time-domain sample width.
REQ-002 Parameter N, default 256: FFT frame length in samples; power of two, at least 4.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 sample_valid  input  1  sample_in carries a new audio sample this cycle.
REQ-006 sample_in  input  WIDTH  signed sample.
REQ-007 fft_start  output  1  one-cycle start pulse to the FFT core.
REQ-008 fft_done  input  1  FFT core completion flag, level or pulse.
REQ-009 fft_samples  output  WIDTH x [0:N-1] unpacked  frame presented to the FFT core.
REQ-010 frame_done  output  1  one-cycle pulse: FFT results for the current frame are valid.
REQ-011 overflow  output  1  one-cycle pulse: a completed frame was discarded.
REQ-012 busy  output  1  high while the FFT owns a bank.

Function
REQ-013 The block SHALL hold two sample banks of N words: one fill bank and one compute bank.
REQ-014 On sample_valid, sample_in SHALL be written to fill[wptr], and wptr SHALL increment, wrapping from N-1 to 0; samples are never stalled.
REQ-015 A write at wptr=N-1 SHALL mark the fill bank full at that edge.
REQ-016 FSM states: IDLE, START, BUSY.
- IDLE: no frame owned.
- START: fft_start=1 for exactly one cycle, then go to BUSY.
- BUSY: hold until fft_done=1.
REQ-017 fft_done SHALL be ignored in IDLE and START.
REQ-018 Full in IDLE SHALL swap banks at the same edge and enter START; the next fill-bank frame write lands at index 0 of the other bank.
- Latency: fft_start is high in the cycle after the N-th write.
REQ-019 fft_done=1 in BUSY SHALL drive frame_done=1 in the next cycle and return the FSM to IDLE.
REQ-020 Full in START or BUSY SHALL discard the fill bank (no swap; wptr already wrapped to 0) and drive overflow=1 in the next cycle.
REQ-021 Full in the same cycle as fft_done in BUSY SHALL count as free: swap, frame_done=1, and START next cycle; no overflow.
REQ-022 fft_samples SHALL reflect the compute bank and stay stable from START until the FSM leaves BUSY.
REQ-023 busy SHALL be 1 in START and BUSY, and 0 otherwise.
REQ-024 fft_start, frame_done and overflow SHALL never be high for two consecutive cycles.

Reset
REQ-025 rst=1 SHALL force state IDLE, wptr 0, fill bank index 0, fft_start 0, frame_done 0, overflow 0, busy 0, and drop_count 0, all at the next edge.
REQ-026 Bank contents are not reset; fft_samples is undefined until the first swap.
REQ-027 rst during START or BUSY SHALL abandon the frame; a later fft_done SHALL produce no frame_done.
REQ-028 A sample_valid during the rst cycle SHALL be dropped.

Configuration
REQ-029 Macro FFT_FRAME_DROP_COUNT_EN defined: add output drop_count [7:0], incremented on every overflow pulse, saturating at 255, and cleared by rst.
REQ-030 Macro FFT_FRAME_DROP_COUNT_EN undefined: drop_count does not exist; all other behaviour is identical.

Verification
REQ-031 N=256: reset, then 256 consecutive sample_valid with sample_in = index -> fft_start high exactly 1 cycle after the 256th write; fft_samples[k]=k; busy=1.
REQ-032 In BUSY, assert fft_done 1 cycle -> frame_done high next cycle for 1 cycle; state IDLE; busy=0; no overflow.
REQ-033 Hold fft_done=0 and stream 512 further samples -> overflow pulses at the end of frames 2 and 3; fft_samples unchanged; drop_count=2 when enabled.
REQ-034 fft_done coincident with the 256th write of frame 2 -> frame_done and fft_start high together next cycle; overflow stays 0; fft_samples shows frame 2.
REQ-035 Assert rst 1 cycle in BUSY, then pulse fft_done -> no frame_done; wptr=0; all outputs 0.
REQ-036 With FFT_FRAME_DROP_COUNT_EN, force 300 overflows -> drop_count holds at 255.
